// File: rtl/pipe_decoder.sv
// ---------------------------------------------------------------------------
// pipe_decoder
//
// Registered, flow-controlled binary-to-N decoder. Each accepted code is
// turned into either a one-hot or a thermometer vector and stored in a
// two-entry output stage (main + skid). The stage gives full throughput
// while keeping in_ready a function of registered state only.
//
// Parameters
//   ENCODE_WIDTH  width of the input code
//   NUM_OUTPUTS   number of decoded output lines (2 .. 2**ENCODE_WIDTH)
//
// Ports
//   i_clk         clock, all state changes on the rising edge
//   i_rst         synchronous active-high reset
//   i_in_valid    producer presents a code
//   o_in_ready    block can take a code (transfer on valid && ready)
//   i_in_code     binary code to decode
//   i_in_mode     0 = one-hot, 1 = thermometer, sampled with the code
//   o_out_valid   o_out / o_out_err hold a decoded result
//   i_out_ready   consumer takes the result (transfer on valid && ready)
//   o_out         decoded vector
//   o_out_err     stored code was out of range
//
// Configuration macro
//   PIPE_DECODER_ERR_EN  when defined, an out-of-range code stores an
//                        error flag next to its all-zero vector. When not
//                        defined, the error bit is not stored at all and
//                        o_out_err is tied low.
// ---------------------------------------------------------------------------
module pipe_decoder #(
   parameter int ENCODE_WIDTH = 4,
   parameter int NUM_OUTPUTS  = 2**ENCODE_WIDTH
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_in_valid,
   output logic                    o_in_ready,
   input  logic [ENCODE_WIDTH-1:0] i_in_code,
   input  logic                    i_in_mode,
   output logic                    o_out_valid,
   input  logic                    i_out_ready,
   output logic [NUM_OUTPUTS-1:0]  o_out,
   output logic                    o_out_err
);

   // One extra bit so that line indices and NUM_OUTPUTS itself never wrap
   // when compared against the code.
   localparam int CW = ENCODE_WIDTH + 1;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_nextState;

   logic                    w_accept;
   logic                    w_fire;
   logic                    w_loadMain;
   logic                    w_mainFromSkid;
   logic                    w_loadSkid;

   logic [CW-1:0]           w_codeExt;
   logic                    w_inRange;
   logic [NUM_OUTPUTS-1:0]  w_decOut;

   logic [NUM_OUTPUTS-1:0]  r_mainOut;
   logic [NUM_OUTPUTS-1:0]  r_skidOut;

`ifdef PIPE_DECODER_ERR_EN
   logic                    w_decErr;
   logic                    r_mainErr;
   logic                    r_skidErr;
`endif

   assign w_codeExt = {1'b0, i_in_code};
   assign w_inRange = (w_codeExt < CW'(NUM_OUTPUTS));

   // Handshake events, expressed directly from registered state so that the
   // control logic never feeds back through its own outputs.
   assign w_accept = i_in_valid && (r_state != FULL) && !i_rst;
   assign w_fire   = (r_state != EMPTY) && i_out_ready;

   // Decode of the incoming code. An out-of-range code forces the whole
   // vector to zero; without that gate thermometer mode would light every
   // line for a code past the top.
   always_comb begin
      w_decOut = '0;
      for (int k = 0; k < NUM_OUTPUTS; k++) begin
         if (w_inRange) begin
            if (i_in_mode)
               w_decOut[k] = (CW'(k) <= w_codeExt);
            else
               w_decOut[k] = (CW'(k) == w_codeExt);
         end
      end
   end

`ifdef PIPE_DECODER_ERR_EN
   assign w_decErr = !w_inRange;
`endif

   // State register: how many decoded results the output stage holds.
   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_state <= EMPTY;
      else
         r_state <= w_nextState;
   end

   // Next-state logic: occupancy moves up on an accept without a fire and
   // down on a fire without an accept. FULL never accepts.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         EMPTY: begin
            if (w_accept)
               w_nextState = ONE;
         end
         ONE: begin
            if (w_accept && !w_fire)
               w_nextState = FULL;
            else if (!w_accept && w_fire)
               w_nextState = EMPTY;
         end
         FULL: begin
            if (w_fire)
               w_nextState = ONE;
         end
         default: w_nextState = EMPTY;
      endcase
   end

   // Output logic: handshake flags plus the register-load strobes for the
   // datapath. A new code goes to main whenever main is free or being
   // emptied this cycle, otherwise into skid.
   always_comb begin
      o_in_ready     = (r_state != FULL) && !i_rst;
      o_out_valid    = (r_state != EMPTY);
      w_loadMain     = 1'b0;
      w_mainFromSkid = 1'b0;
      w_loadSkid     = 1'b0;
      case (r_state)
         EMPTY: begin
            w_loadMain = w_accept;
         end
         ONE: begin
            w_loadMain = w_accept && w_fire;
            w_loadSkid = w_accept && !w_fire;
         end
         FULL: begin
            w_mainFromSkid = w_fire;
         end
         default: begin
            w_loadMain = 1'b0;
         end
      endcase
   end

   // Main and skid storage. Main drives the outputs directly, so it only
   // changes on a load, which keeps the result stable under backpressure.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mainOut <= '0;
         r_skidOut <= '0;
`ifdef PIPE_DECODER_ERR_EN
         r_mainErr <= 1'b0;
         r_skidErr <= 1'b0;
`endif
      end else begin
         if (w_loadMain) begin
            r_mainOut <= w_decOut;
`ifdef PIPE_DECODER_ERR_EN
            r_mainErr <= w_decErr;
`endif
         end else if (w_mainFromSkid) begin
            r_mainOut <= r_skidOut;
`ifdef PIPE_DECODER_ERR_EN
            r_mainErr <= r_skidErr;
`endif
         end
         if (w_loadSkid) begin
            r_skidOut <= w_decOut;
`ifdef PIPE_DECODER_ERR_EN
            r_skidErr <= w_decErr;
`endif
         end
      end
   end

   assign o_out = r_mainOut;

`ifdef PIPE_DECODER_ERR_EN
   assign o_out_err = r_mainErr;
`else
   assign o_out_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_decoder.sv
// ---------------------------------------------------------------------------
// tb_pipe_decoder
//
// Self-checking bench for pipe_decoder. Two instances: a full 16-line
// decoder that carries the main traffic, and a 10-line decoder for the
// out-of-range codes. A queue-based reference model follows every handshake
// of the 16-line instance and its expected head result is compared with the
// outputs on every falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_decoder;

`ifdef PIPE_DECODER_ERR_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;

   logic        inValid;
   logic        inReady;
   logic [3:0]  inCode;
   logic        inMode;
   logic        outValid;
   logic        outReady;
   logic [15:0] outVec;
   logic        outErr;

   logic        v1Valid;
   logic        v1Ready;
   logic [3:0]  v1Code;
   logic        v1Mode;
   logic        v1OutValid;
   logic        v1OutReady;
   logic [9:0]  v1Out;
   logic        v1Err;

   int nCompared   = 0;
   int nMismatched = 0;

   // Expected results held by the output stage, oldest first: {err, vector}.
   logic [16:0] modelQ[$];

   typedef struct {
      logic [3:0]  code;
      logic        mode;
      logic [15:0] expOut;
   } vec_t;

   vec_t vecs[21];

   pipe_decoder #(.ENCODE_WIDTH(4), .NUM_OUTPUTS(16)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_valid  (inValid),
      .o_in_ready  (inReady),
      .i_in_code   (inCode),
      .i_in_mode   (inMode),
      .o_out_valid (outValid),
      .i_out_ready (outReady),
      .o_out       (outVec),
      .o_out_err   (outErr)
   );

   pipe_decoder #(.ENCODE_WIDTH(4), .NUM_OUTPUTS(10)) dut10 (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_valid  (v1Valid),
      .o_in_ready  (v1Ready),
      .i_in_code   (v1Code),
      .i_in_mode   (v1Mode),
      .o_out_valid (v1OutValid),
      .i_out_ready (v1OutReady),
      .o_out       (v1Out),
      .o_out_err   (v1Err)
   );

   always #5 clk = ~clk;

   // Reference decode straight from the arithmetic definition.
   function automatic logic [16:0] modelDecode(input int code, input logic mode, input int n);
      logic [31:0] v;
      if (code >= n)
         return {ERR_EXP, 16'h0000};
      if (mode)
         v = (32'd1 << (code + 1)) - 32'd1;
      else
         v = 32'd1 << code;
      return {1'b0, v[15:0]};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [3:0] code, input logic mode, input logic ready);
      inValid  = valid;
      inCode   = code;
      inMode   = mode;
      outReady = ready;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model update on each rising edge: at most two results held, a fire
   // removes the oldest and an accept appends the new decode.
   always @(posedge clk) begin
      logic acc;
      logic fire;
      if (rst) begin
         modelQ.delete();
      end else begin
         acc  = inValid && (modelQ.size() < 2);
         fire = (modelQ.size() > 0) && outReady;
         if (fire)
            void'(modelQ.pop_front());
         if (acc)
            modelQ.push_back(modelDecode(int'(inCode), inMode, 16));
      end
   end

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin
      checkOutput("mon_in_ready", 32'(inReady), 32'(!rst && (modelQ.size() < 2)));
      checkOutput("mon_out_valid", 32'(outValid), 32'(modelQ.size() > 0));
      if (modelQ.size() > 0) begin
         checkOutput("mon_out", 32'(outVec), 32'(modelQ[0][15:0]));
         checkOutput("mon_out_err", 32'(outErr), 32'(modelQ[0][16]));
      end
   end

   initial begin
      // Vector table: one-hot sweep followed by thermometer cases.
      for (int i = 0; i < 16; i++) begin
         vecs[i].code   = 4'(i);
         vecs[i].mode   = 1'b0;
         vecs[i].expOut = 16'(32'd1 << i);
      end
      vecs[16] = '{4'd5,  1'b1, 16'h003F};
      vecs[17] = '{4'd15, 1'b1, 16'hFFFF};
      vecs[18] = '{4'd0,  1'b1, 16'h0001};
      vecs[19] = '{4'd8,  1'b1, 16'h01FF};
      vecs[20] = '{4'd3,  1'b0, 16'h0008};

      rst = 1'b1;
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
      v1Valid = 1'b0; v1Code = 4'd0; v1Mode = 1'b0; v1OutReady = 1'b1;

      // Reset state.
      tick();
      tick();
      checkOutput("rst_in_ready", 32'(inReady), 32'd0);
      checkOutput("rst_out_valid", 32'(outValid), 32'd0);
      checkOutput("rst_out", 32'(outVec), 32'd0);
      checkOutput("rst_out_err", 32'(outErr), 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("rel_in_ready", 32'(inReady), 32'd1);

      // Back-to-back table vectors with out_ready high: one result per cycle.
      for (int i = 0; i < 21; i++) begin
         applyStimulus(1'b1, vecs[i].code, vecs[i].mode, 1'b1);
         tick();
         checkOutput($sformatf("vec%0d_out", i), 32'(outVec), 32'(vecs[i].expOut));
         checkOutput($sformatf("vec%0d_valid", i), 32'(outValid), 32'd1);
         checkOutput($sformatf("vec%0d_in_ready", i), 32'(inReady), 32'd1);
      end
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
      tick();
      checkOutput("drain_valid", 32'(outValid), 32'd0);

      // Backpressure: second code lands in skid, main held.
      applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
      tick();
      checkOutput("bp1_out", 32'(outVec), 32'h0008);
      checkOutput("bp1_in_ready", 32'(inReady), 32'd1);
      applyStimulus(1'b1, 4'd7, 1'b0, 1'b0);
      tick();
      checkOutput("bp2_out", 32'(outVec), 32'h0008);
      checkOutput("bp2_in_ready", 32'(inReady), 32'd0);
      applyStimulus(1'b1, 4'd9, 1'b0, 1'b0);
      tick();
      checkOutput("bp3_held_out", 32'(outVec), 32'h0008);
      checkOutput("bp3_in_ready", 32'(inReady), 32'd0);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
      #1;
      checkOutput("bp4_out", 32'(outVec), 32'h0008);
      tick();
      checkOutput("bp5_out", 32'(outVec), 32'h0080);
      checkOutput("bp5_in_ready", 32'(inReady), 32'd1);
      tick();
      checkOutput("bp6_valid", 32'(outValid), 32'd0);

      // Reset while FULL discards both held results.
      applyStimulus(1'b1, 4'd1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 4'd4, 1'b0, 1'b0);
      tick();
      checkOutput("full_in_ready", 32'(inReady), 32'd0);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checkOutput("frst_valid", 32'(outValid), 32'd0);
      checkOutput("frst_out", 32'(outVec), 32'd0);
      checkOutput("frst_in_ready", 32'(inReady), 32'd1);
      applyStimulus(1'b1, 4'd2, 1'b0, 1'b1);
      tick();
      checkOutput("frst_code2", 32'(outVec), 32'h0004);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
      tick();

      // Ten-line instance: out-of-range codes.
      v1Valid = 1'b1; v1Code = 4'd12; v1Mode = 1'b0;
      tick();
      checkOutput("n10_c12_out", 32'(v1Out), 32'h000);
      checkOutput("n10_c12_err", 32'(v1Err), 32'(ERR_EXP));
      checkOutput("n10_c12_valid", 32'(v1OutValid), 32'd1);
      v1Code = 4'd9;
      tick();
      checkOutput("n10_c9_out", 32'(v1Out), 32'h200);
      checkOutput("n10_c9_err", 32'(v1Err), 32'd0);
      v1Code = 4'd12; v1Mode = 1'b1;
      tick();
      checkOutput("n10_c12t_out", 32'(v1Out), 32'h000);
      checkOutput("n10_c12t_err", 32'(v1Err), 32'(ERR_EXP));
      v1Code = 4'd9;
      tick();
      checkOutput("n10_c9t_out", 32'(v1Out), 32'h3FF);
      checkOutput("n10_c9t_err", 32'(v1Err), 32'd0);
      v1Valid = 1'b0;
      tick();
      checkOutput("n10_idle_valid", 32'(v1OutValid), 32'd0);

      // Random traffic; the model compares every cycle.
      for (int i = 0; i < 1000; i++) begin
         applyStimulus($urandom_range(0, 99) < 60,
                       4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)),
                       $urandom_range(0, 99) < 65);
         tick();
      end
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
      tick();
      tick();
      tick();
      checkOutput("final_valid", 32'(outValid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
